imem_loader: RTL

- Instruction-memory stage feeding the accumulator core: owns the program store, answers the core's fetch address `pc` with `opcode`/`operand`, and holds the core in reset while a program is loaded.
- Programs arrive as a byte stream from a host over a valid/ready handshake.
- `core_rst_n` drives the core's `rst_n` directly.
- Core writes never reach this block; the core is never running while the store is being written.

---
 rtl/imem_loader.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Instruction store for the accumulator core, plus a byte-stream program
// loader that holds the core in reset while a program is written.
//
// Load stream format (host -> loader, one byte per accepted beat):
//   N, then N words as {hi, lo} byte pairs. With LOADER_CHECKSUM_EN defined,
//   a final checksum byte C follows. C is the 8-bit sum of the 2N data bytes.
//
// Handshake: a byte transfers on a rising clk edge where in_valid && in_ready.
//   in_ready depends only on the current state. The host may hold in_valid
//   for any length of time. Bytes presented while in_ready=0 are never taken.
//
// Optional feature macro: LOADER_CHECKSUM_EN (adds the CSUM state and err).
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   load_req         one-cycle pulse that starts a load (ignored while busy)
//   in_data/valid    host byte stream; in_ready = loader takes byte this cycle
//   pc               core fetch address
//   opcode/operand   combinational fetch data for mem[pc]
//   core_rst_n       registered; 0 holds the core in reset
//   busy             registered; 1 while a load is in progress
//   err              (LOADER_CHECKSUM_EN only) sticky checksum-mismatch flag
//   fsm_state        current loader state, for observation
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int OPCODE_W = 4,
    parameter int ADDR_W   = 8     // OPCODE_W + ADDR_W must not exceed 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_req,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ADDR_W-1:0]   pc,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   operand,
    output logic                core_rst_n,
    output logic                busy,
`ifdef LOADER_CHECKSUM_EN
    output logic                err,
`endif
    output logic [2:0]          fsm_state
);

    localparam int INSN_W = OPCODE_W + ADDR_W;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic [2:0] {
        S_HALT = 3'd0,
        S_RUN  = 3'd1,
        S_LEN  = 3'd2,
        S_HI   = 3'd3,
        S_LO   = 3'd4,
        S_CSUM = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] wcnt_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [7:0]        hi_q;
    logic [ADDR_W-1:0] len_in;
    logic              take;
    logic              last_word;
    logic              mem_we;
    logic [INSN_W-1:0] mem_wdata;
    logic [INSN_W-1:0] insn;
    state_t            done_state;

    logic [INSN_W-1:0] mem [DEPTH];

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;
    logic       csum_ok;
    assign csum_ok    = (in_data == sum_q);
    assign done_state = S_CSUM;
`else
    assign done_state = S_RUN;
`endif

    // Word count is 8 bits on the wire; the cast truncates (or zero-extends)
    // it to the address width.
    assign len_in    = ADDR_W'(in_data);
    assign take      = in_valid && in_ready;
    assign last_word = (wcnt_q == (len_q - ADDR_W'(1)));
    assign mem_we    = (state_q == S_LO) && take;
    assign mem_wdata = INSN_W'({hi_q, in_data});
    assign fsm_state = state_q;

    // Next-state and handshake logic.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_HALT, S_RUN: begin
                if (load_req) state_d = S_LEN;
            end
            S_LEN: begin
                in_ready = 1'b1;
                if (take) state_d = (len_in == '0) ? done_state : S_HI;
            end
            S_HI: begin
                in_ready = 1'b1;
                if (take) state_d = S_LO;
            end
            S_LO: begin
                in_ready = 1'b1;
                if (take) state_d = last_word ? done_state : S_HI;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                in_ready = 1'b1;
                if (take) state_d = csum_ok ? S_RUN : S_HALT;
            end
`endif
            default: state_d = S_HALT;
        endcase
    end

    // State, registered outputs and load bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_HALT;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            len_q      <= '0;
            wcnt_q     <= '0;
            waddr_q    <= '0;
            hi_q       <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q      <= '0;
            err        <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            // Both outputs look one state ahead so they change on the same
            // edge that enters the new state.
            core_rst_n <= (state_d == S_RUN);
            busy       <= (state_d == S_LEN) || (state_d == S_HI) ||
                          (state_d == S_LO)  || (state_d == S_CSUM);
            case (state_q)
                S_HALT, S_RUN: begin
`ifdef LOADER_CHECKSUM_EN
                    if (load_req) err <= 1'b0;
`endif
                end
                S_LEN: begin
                    if (take) begin
                        len_q   <= len_in;
                        wcnt_q  <= '0;
                        waddr_q <= '0;
`ifdef LOADER_CHECKSUM_EN
                        sum_q   <= '0;
`endif
                    end
                end
                S_HI: begin
                    if (take) begin
                        hi_q  <= in_data;
`ifdef LOADER_CHECKSUM_EN
                        sum_q <= sum_q + in_data;
`endif
                    end
                end
                S_LO: begin
                    if (take) begin
                        // The write address wraps naturally at 2**ADDR_W.
                        waddr_q <= waddr_q + ADDR_W'(1);
                        wcnt_q  <= wcnt_q + ADDR_W'(1);
`ifdef LOADER_CHECKSUM_EN
                        sum_q   <= sum_q + in_data;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CSUM: begin
                    if (take && !csum_ok) err <= 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

    // The program store is deliberately not reset: words written before an
    // aborted load survive it.
    always_ff @(posedge clk) begin
        if (mem_we) mem[waddr_q] <= mem_wdata;
    end

    // Fetch port: pure combinational read, valid in every state.
    assign insn    = mem[pc];
    assign opcode  = insn[INSN_W-1:ADDR_W];
    assign operand = insn[ADDR_W-1:0];

endmodule
